// File: rtl/pwmout_pkg.sv
// Shared definitions for the multi-channel ESC PWM generator: mode encoding,
// microsecond-to-tick conversion and a constant-safe clog2.
package pwmout_pkg;

    typedef enum logic {
        MODE_STD   = 1'b0,
        MODE_OS125 = 1'b1
    } mode_e;

    function automatic int unsigned ticks(input int unsigned us, input int unsigned clk_hz);
        return us * (clk_hz / 1000000);
    endfunction

    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pwmout_multi_if.sv
// Control/output bundle between the DShot decoder side and the PWM generator.
interface pwmout_multi_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned SPEED_W = 8
);
    logic                        enable;
    logic                        mode;
    logic [NUM_CH*SPEED_W-1:0]   targetSpeed;
    logic [NUM_CH-1:0]           pwmPin;
    logic                        frameStart;

    modport master (
        output enable, mode, targetSpeed,
        input  pwmPin, frameStart
    );

    modport slave (
        input  enable, mode, targetSpeed,
        output pwmPin, frameStart
    );
endinterface

// File: rtl/pwm_channel.sv
// One PWM output channel: width computation, optional slew register (PWMOUT_MULTI_SLEW_EN),
// compare against the shared frame position, registered pin.
module pwm_channel
    import pwmout_pkg::*;
#(
    parameter int unsigned CW      = 15,
    parameter int unsigned SPEED_W = 8,
    parameter int unsigned MIN_T   = 12000,
    parameter int unsigned MAX_T   = 24000
`ifdef PWMOUT_MULTI_SLEW_EN
    ,
    parameter int unsigned SLEW_STEP = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               start,
    input  logic [CW-1:0]      pos,
    input  mode_e              frame_mode,
    input  logic [SPEED_W-1:0] speed,
    output logic               pwm
);

    localparam int unsigned SPAN_T = MAX_T - MIN_T;
    localparam int unsigned PW     = SPEED_W + CW;

    logic [SPEED_W-1:0] spd;
    logic [PW-1:0]      prod;
    logic [CW-1:0]      w_new;
    logic [CW-1:0]      w_q;
    logic [CW-1:0]      w_cur;
    logic [CW-1:0]      w_eff;

`ifdef PWMOUT_MULTI_SLEW_EN
    localparam logic [SPEED_W:0] STEP_P = (SPEED_W+1)'(SLEW_STEP);

    logic [SPEED_W-1:0] act_q;
    logic [SPEED_W-1:0] act_nxt;

    always_comb begin
        act_nxt = speed;
        if (speed > act_q) begin
            if ({1'b0, speed - act_q} > STEP_P) act_nxt = act_q + SPEED_W'(SLEW_STEP);
        end else if ({1'b0, act_q - speed} > STEP_P) begin
            act_nxt = act_q - SPEED_W'(SLEW_STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          act_q <= '0;
        else if (!enable) act_q <= '0;
        else if (start)   act_q <= act_nxt;
    end

    assign spd = act_nxt;
`else
    assign spd = speed;
`endif

    // Full-scale speed maps to MAX_T exactly; the shift alone would fall short.
    always_comb begin
        prod  = PW'(spd) * PW'(SPAN_T);
        w_new = (spd == '1) ? CW'(MAX_T) : CW'(MIN_T) + CW'(prod >> SPEED_W);
        w_cur = start ? w_new : w_q;
        w_eff = (frame_mode == MODE_OS125) ? (w_cur >> 3) : w_cur;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            pwm <= 1'b0;
        end else if (!enable) begin
            pwm <= 1'b0;
        end else begin
            if (start) w_q <= w_new;
            pwm <= (pos < w_eff);
        end
    end

endmodule

// File: rtl/pwmout_multi.sv
// Multi-channel ESC PWM generator: shared frame counter, enable, frameStart and mode latch.
// Optional per-channel slew limiting under PWMOUT_MULTI_SLEW_EN.
module pwmout_multi
    import pwmout_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 12000000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned SPEED_W  = 8,
    parameter int unsigned FRAME_US = 2500,
    parameter int unsigned MIN_US   = 1000,
    parameter int unsigned MAX_US   = 2000
`ifdef PWMOUT_MULTI_SLEW_EN
    ,
    parameter int unsigned SLEW_STEP = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    pwmout_multi_if.slave  bus
);

    localparam int unsigned FRAME_T = ticks(FRAME_US, CLK_HZ);
    localparam int unsigned MIN_T   = ticks(MIN_US, CLK_HZ);
    localparam int unsigned MAX_T   = ticks(MAX_US, CLK_HZ);
    localparam int unsigned CW      = clog2_u(FRAME_T);

    if (MAX_US >= FRAME_US) begin : g_bad_cfg
        $error("pwmout_multi: MAX_US must be below FRAME_US");
    end

    logic              running;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     nxt;
    logic              start;
    logic              fs_q;
    mode_e             mode_q;
    mode_e             frame_mode;
    logic [NUM_CH-1:0] pwm;

    // nxt is the frame position the outputs will show after this edge; from idle it is 0.
    always_comb begin
        nxt = '0;
        if (running) nxt = (cnt == CW'(FRAME_T - 1)) ? '0 : cnt + CW'(1);
        start      = bus.enable && (nxt == '0);
        frame_mode = start ? mode_e'(bus.mode) : mode_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            fs_q    <= 1'b0;
            mode_q  <= MODE_STD;
        end else if (!bus.enable) begin
            running <= 1'b0;
            cnt     <= '0;
            fs_q    <= 1'b0;
        end else begin
            running <= 1'b1;
            cnt     <= nxt;
            fs_q    <= start;
            if (start) mode_q <= mode_e'(bus.mode);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .CW       (CW),
            .SPEED_W  (SPEED_W),
            .MIN_T    (MIN_T),
            .MAX_T    (MAX_T)
`ifdef PWMOUT_MULTI_SLEW_EN
            ,
            .SLEW_STEP(SLEW_STEP)
`endif
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (bus.enable),
            .start     (start),
            .pos       (nxt),
            .frame_mode(frame_mode),
            .speed     (bus.targetSpeed[i*SPEED_W +: SPEED_W]),
            .pwm       (pwm[i])
        );
    end

    assign bus.pwmPin     = pwm;
    assign bus.frameStart = fs_q;

endmodule

// File: tb/tb_pwmout_multi.sv
// Self-checking bench for pwmout_multi: table vectors, randomized frames against a
// frame-level reference model, and hand-written enable/reset/wrap sequences.
module tb_pwmout_multi;

    localparam int CLK_HZ   = 2000000;
    localparam int NUM_CH   = 4;
    localparam int SPEED_W  = 8;
    localparam int FRAME_US = 250;
    localparam int MIN_US   = 100;
    localparam int MAX_US   = 200;
    localparam int SLEW_STEP = 16;
    localparam int FRAME_T  = 500;
    localparam int MIN_T    = 200;
    localparam int MAX_T    = 400;
    localparam int FULL     = 255;

    logic clk = 1'b0;
    logic rst;

    pwmout_multi_if #(.NUM_CH(NUM_CH), .SPEED_W(SPEED_W)) bus ();

    pwmout_multi #(
        .CLK_HZ   (CLK_HZ),
        .NUM_CH   (NUM_CH),
        .SPEED_W  (SPEED_W),
        .FRAME_US (FRAME_US),
        .MIN_US   (MIN_US),
        .MAX_US   (MAX_US)
`ifdef PWMOUT_MULTI_SLEW_EN
        ,
        .SLEW_STEP(SLEW_STEP)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int act_spd [NUM_CH];
    int exp_w   [NUM_CH];
    int m_hi    [NUM_CH];
    int m_want  [NUM_CH];
    int m_len;
    int m_contig;

    typedef struct {
        logic [31:0]             spd;
        logic                    md;
        logic [NUM_CH-1:0][15:0] want;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int ref_width(input int spd, input logic md);
        int w;
        if (spd == FULL) w = MAX_T;
        else             w = MIN_T + (spd * (MAX_T - MIN_T)) / 256;
        if (md) w = w / 8;
        return w;
    endfunction

    // Frame-level model: called at each observed frame start, before inputs move.
    task automatic on_frame_start();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int tgt;
            tgt = int'(bus.targetSpeed[ch*SPEED_W +: SPEED_W]);
`ifdef PWMOUT_MULTI_SLEW_EN
            if (tgt > act_spd[ch])      act_spd[ch] = (tgt - act_spd[ch] > SLEW_STEP) ? act_spd[ch] + SLEW_STEP : tgt;
            else if (tgt < act_spd[ch]) act_spd[ch] = (act_spd[ch] - tgt > SLEW_STEP) ? act_spd[ch] - SLEW_STEP : tgt;
`else
            act_spd[ch] = tgt;
`endif
            exp_w[ch] = ref_width(act_spd[ch], bus.mode);
        end
    endtask

    task automatic model_idle();
        for (int ch = 0; ch < NUM_CH; ch++) act_spd[ch] = 0;
    endtask

    // Measures one frame from a frameStart negedge up to the next one.
    task automatic meas(input int chg_at, input logic [31:0] chg_spd, input logic chg_mode);
        bit seen_low [NUM_CH];
        m_len = 0;
        m_contig = 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_want[ch] = exp_w[ch];
            m_hi[ch] = 0;
            seen_low[ch] = 1'b0;
        end
        do begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (bus.pwmPin[ch]) begin
                    if (seen_low[ch]) m_contig = 0;
                    m_hi[ch]++;
                end else begin
                    seen_low[ch] = 1'b1;
                end
            end
            m_len++;
            if (m_len == chg_at) begin
                bus.targetSpeed = chg_spd;
                bus.mode = chg_mode;
            end
            @(negedge clk);
        end while (!bus.frameStart && m_len < 2 * FRAME_T);
        if (bus.frameStart) on_frame_start();
    endtask

    task automatic check_meas(input string name);
        chk({name, "_len"}, m_len, FRAME_T);
        chk({name, "_contig"}, m_contig, 1);
        for (int ch = 0; ch < NUM_CH; ch++)
            chk($sformatf("%s_ch%0d", name, ch), m_hi[ch], m_want[ch]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h00000000, 1'b0, {16'd200, 16'd200, 16'd200, 16'd200}};
        tbl[1] = '{32'h80808080, 1'b0, {16'd300, 16'd300, 16'd300, 16'd300}};
        tbl[2] = '{32'hFFFFFFFF, 1'b0, {16'd400, 16'd400, 16'd400, 16'd400}};
        tbl[3] = '{32'hFFC04000, 1'b0, {16'd400, 16'd350, 16'd250, 16'd200}};
        tbl[4] = '{32'hFFC04000, 1'b1, {16'd50,  16'd43,  16'd31,  16'd25}};
        tbl[5] = '{32'h40FF8000, 1'b1, {16'd31,  16'd50,  16'd37,  16'd25}};

        rst = 1'b1;
        bus.enable = 1'b1;
        bus.mode = 1'b0;
        bus.targetSpeed = '0;
        model_idle();
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(bus.pwmPin), 0);
        chk("reset_fs", int'(bus.frameStart), 0);

        rst = 1'b0;
        @(negedge clk);
        chk("start_fs", int'(bus.frameStart), 1);
        chk("start_rise", int'(bus.pwmPin), 15);
        on_frame_start();
        meas(-1, '0, 1'b0);
        check_meas("first");

`ifndef PWMOUT_MULTI_SLEW_EN
        for (int v = 0; v < 6; v++) begin
            bus.targetSpeed = tbl[v].spd;
            bus.mode = tbl[v].md;
            meas(-1, '0, 1'b0);
            meas(-1, '0, 1'b0);
            chk($sformatf("tbl%0d_len", v), m_len, FRAME_T);
            chk($sformatf("tbl%0d_contig", v), m_contig, 1);
            for (int ch = 0; ch < NUM_CH; ch++)
                chk($sformatf("tbl%0d_ch%0d", v, ch), m_hi[ch], int'(tbl[v].want[ch]));
        end
`endif

        // Mid-frame speed change, then mid-frame mode change.
        bus.targetSpeed = '0;
        bus.mode = 1'b0;
        meas(-1, '0, 1'b0);
        meas(100, 32'hFFFFFFFF, 1'b0);
        check_meas("spdchg_cur");
        meas(-1, '0, 1'b0);
        check_meas("spdchg_next");
        meas(50, 32'hFFFFFFFF, 1'b1);
        check_meas("modechg_cur");
        meas(-1, '0, 1'b0);
        check_meas("modechg_next");

        for (int r = 0; r < 12; r++) begin
            logic [31:0] s;
            s = $urandom;
            if ($urandom_range(3) == 0) s[7:0] = 8'hFF;
            if ($urandom_range(3) == 0) s[31:24] = 8'h00;
            bus.targetSpeed = s;
            bus.mode = 1'($urandom_range(1));
            meas(-1, '0, 1'b0);
            meas(-1, '0, 1'b0);
            check_meas($sformatf("rnd%0d", r));
        end

        // Enable dropped mid-pulse.
        bus.targetSpeed = 32'h80808080;
        bus.mode = 1'b0;
        meas(-1, '0, 1'b0);
        repeat (120) @(negedge clk);
        chk("pre_drop_pwm", int'(bus.pwmPin), 15);
        bus.enable = 1'b0;
        model_idle();
        @(negedge clk);
        chk("drop_pwm", int'(bus.pwmPin), 0);
        chk("drop_fs", int'(bus.frameStart), 0);
        begin
            int bad;
            bad = 0;
            repeat (600) begin
                @(negedge clk);
                if (bus.frameStart || bus.pwmPin != '0) bad++;
            end
            chk("idle_quiet", bad, 0);
        end
        bus.enable = 1'b1;
        @(negedge clk);
        chk("reen_fs", int'(bus.frameStart), 1);
        on_frame_start();
        meas(-1, '0, 1'b0);
        check_meas("reen");

        // Enable falling on the wrap edge: no frameStart.
        repeat (FRAME_T - 1) @(negedge clk);
        bus.enable = 1'b0;
        model_idle();
        @(negedge clk);
        chk("wrap_idle_fs", int'(bus.frameStart), 0);
        chk("wrap_idle_pwm", int'(bus.pwmPin), 0);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("wrap_reen_fs", int'(bus.frameStart), 1);
        on_frame_start();

        // Asynchronous reset mid-pulse.
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_pwm", int'(bus.pwmPin), 0);
        chk("rst_async_fs", int'(bus.frameStart), 0);
        model_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_fs", int'(bus.frameStart), 1);
        on_frame_start();
        meas(-1, '0, 1'b0);
        check_meas("rst_rel");

`ifdef PWMOUT_MULTI_SLEW_EN
        bus.enable = 1'b0;
        bus.targetSpeed = '0;
        bus.mode = 1'b0;
        model_idle();
        repeat (3) @(negedge clk);
        bus.targetSpeed = 32'hFFFFFFFF;
        bus.enable = 1'b1;
        @(negedge clk);
        on_frame_start();
        for (int f = 0; f < 17; f++) begin
            meas(-1, '0, 1'b0);
            check_meas($sformatf("slew%0d", f));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwmout_multi.md
Name: pwmout_multi

Overview:
Parametrised, multi-channel ESC PWM generator, successor to the single-channel pwmout.
- Converts per-channel speed words, decoded upstream from DShot, into servo-style throttle pulses on a common frame.
- Supports two pulse modes: standard 1000–2000 us and OneShot125.
- Speed and mode are double-buffered, so updates take effect only at frame boundaries.
- Sits between the DShot decoder and the ESC output pins.

Parameters:
- CLK_HZ, 12000000: system clock frequency in Hz.
- NUM_CH, 4: number of output channels (1..8).
- SPEED_W, 8: speed word width per channel (8..11).
- FRAME_US, 2500: frame period in us (400 Hz).
- MIN_US, 1000: pulse width at speed 0, standard mode.
- MAX_US, 2000: pulse width at full-scale speed, standard mode; must be < FRAME_US (checked at elaboration).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous assert, active-high.
- enable  in  1  output enable; level-sensitive.
- mode  in  1  0 = standard PWM, 1 = OneShot125; sampled at frame start.
- targetSpeed  in  NUM_CH*SPEED_W  channel i at bits [i*SPEED_W +: SPEED_W]; sampled at frame start.
- pwmPin  out  NUM_CH  registered pulse outputs.
- frameStart  out  1  registered one-cycle strobe on the first cycle of each frame.

Behaviour:
- Derived constants:
  - TPU = CLK_HZ/1000000.
  - FRAME_T = FRAME_US*TPU.
  - MIN_T = MIN_US*TPU.
  - MAX_T = MAX_US*TPU.
  - SPAN_T = MAX_T - MIN_T.
  - Counter width = clog2(FRAME_T).
- Reset: pwmPin = 0, frameStart = 0, frame counter = 0, active widths = 0, latched mode = 0.
- Pulse width (standard mode):
  - W = MIN_T + ((speed*SPAN_T) >> SPEED_W).
  - speed == all-ones yields exactly MAX_T.
  - Use a full-width product; no truncation before the shift.
- Pulse width (OneShot125): W_os = W >> 3.
- Idle (enable = 0): counter held at 0; pwmPin and frameStart low from the first edge after enable falls. A pulse in progress is truncated.
- Start: the first edge with enable = 1 begins a frame.
- Frame cycle (counter = 0): frameStart = 1; all channel widths and mode are latched from the inputs on that edge.
- Pulse output: pwmPin[i] is high for exactly W_i consecutive cycles, starting the same cycle frameStart is high, then low until the frame ends.
- Frame advance: the counter increments each cycle and wraps FRAME_T-1 → 0. A new frame starts on the wrap.
- Frame length: exactly FRAME_T cycles; frameStart period = FRAME_T.
- Mid-frame input changes (targetSpeed, mode): no effect on the current frame.
- Channels are independent; all rising edges align to frameStart.
- Reset mid-frame: outputs drop low immediately (asynchronous). After release, behaviour is identical to the start from idle.
- Simultaneous events:
  - Enable falling on the wrap edge: idle wins; no frameStart.
  - rst overrides everything.

Optional Feature:
- Macro: PWMOUT_MULTI_SLEW_EN.
- When defined:
  - Parameter SLEW_STEP (default 16) is added.
  - Each channel keeps an active speed register. At each frame start it moves toward targetSpeed by at most SLEW_STEP, then clamps to the target.
  - The width formula is applied to the active speed.
  - Active speed resets to 0, and also returns to 0 while enable = 0.
- When undefined: the active speed equals the latched targetSpeed directly; no slew registers are synthesised.

Decomposition:
- Package pwmout_pkg:
  - mode encoding constants MODE_STD = 0, MODE_OS125 = 1;
  - a function for tick-constant derivation;
  - a clog2 helper.
- Sub-module pwm_channel, one instance per channel:
  - width computation, optional slew register, compare against the shared counter, registered output.
- The top level owns the frame counter, enable logic, frameStart and mode latch.

Test Plan:
- Defaults, enable = 1, mode = 0, all channels at speed 0, 128, 255 → high for 12000, 18000, 24000 cycles respectively; frameStart period 30000.
- mode = 1 with speeds 0/128/255 → 1500/2250/3000 cycle pulses; mode change mid-frame applies only from the next frameStart.
- Channels 0..3 at speeds 0, 64, 192, 255 in one frame → 12000, 15000, 21000, 24000 cycles; all rise on the frameStart cycle.
- Change targetSpeed 0 → 255 at cycle 5000 of a frame → current pulse 12000, next 24000.
- Enable dropped at cycle 6000 → pwmPin low next cycle, no further frameStart. Re-enable → frameStart on first enabled edge, full-length pulse.
- rst pulsed mid-pulse → pwmPin low asynchronously. With PWMOUT_MULTI_SLEW_EN, step 0 → 255 gives speeds 16, 32, …, 240, 255 over 16 frames.
